// File: rtl/li_pkg.sv
// Shared RV32I constants and FSM state type for the immediate encoder.
package li_pkg;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [2:0] FUNCT3_ADDI = 3'b000;

  // ADDI x0,x0,0 -- emitted for rd==0 so every request still yields one handshake
  localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT_U = 2'd1,
    EMIT_I = 2'd2
  } li_state_t;

endpackage

// File: rtl/li_split.sv
// Splits a 32-bit value into a rounded upper-20 part and a sign-extended lower-12 part.
module li_split
  import li_pkg::*;
(
  input  logic [31:0] i_value,
  input  logic        i_pcrel,
  output logic [19:0] o_hi,
  output logic [11:0] o_lo,
  output logic        o_small,
  output logic        o_lozero
);

  // (value + 0x800)[31:12]: the only carry into bit 12 comes from value[11]
  assign o_hi     = i_value[31:12] + {19'd0, i_value[11]};
  assign o_lo     = i_value[11:0];
  assign o_small  = !i_pcrel && ((&i_value[31:11]) || !(|i_value[31:11]));
  assign o_lozero = (i_value[11:0] == 12'd0);

endmodule

// File: rtl/li_encoder.sv
// Encodes a constant or PC-relative offset into LUI/AUIPC + ADDI instruction words.
module li_encoder
  import li_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_value,
  input  logic [4:0]  req_rd,
  input  logic        req_pcrel,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic        instr_last
);

  li_state_t   r_state;
  logic        r_valid;
  logic        r_last;
  logic [31:0] r_instr;
  logic [31:0] r_addi;

  logic [19:0] w_hi;
  logic [11:0] w_lo;
  logic        w_small;
  logic        w_lozero;
  logic [6:0]  w_uopc;
  logic [31:0] w_uword;
  logic [31:0] w_addi_x0;
  logic [31:0] w_addi_rd;

  li_split u_split (
    .i_value  (req_value),
    .i_pcrel  (req_pcrel),
    .o_hi     (w_hi),
    .o_lo     (w_lo),
    .o_small  (w_small),
    .o_lozero (w_lozero)
  );

  assign w_uopc    = req_pcrel ? OPC_AUIPC : OPC_LUI;
  assign w_uword   = {w_hi, req_rd, w_uopc};
  assign w_addi_x0 = {w_lo, 5'd0, FUNCT3_ADDI, req_rd, OPC_OPIMM};
  assign w_addi_rd = {w_lo, req_rd, FUNCT3_ADDI, req_rd, OPC_OPIMM};

  assign req_ready   = (r_state == IDLE);
  assign instr_valid = r_valid;
  assign instr       = r_instr;
  assign instr_last  = r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_instr <= 32'd0;
      r_addi  <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_valid <= 1'b1;
            if (req_rd == 5'd0) begin
              r_instr <= INSTR_NOP;
              r_last  <= 1'b1;
              r_state <= EMIT_I;
            end else if (w_small) begin
              r_instr <= w_addi_x0;
              r_last  <= 1'b1;
              r_state <= EMIT_I;
            end else begin
              // The ADDI half is captured now so later req_* changes cannot leak in
              r_instr <= w_uword;
              r_addi  <= w_addi_rd;
              r_last  <= w_lozero;
              r_state <= EMIT_U;
            end
          end
        end
        EMIT_U, EMIT_I: begin
          if (instr_ready) begin
            if (!r_last) begin
              r_instr <= r_addi;
              r_last  <= 1'b1;
              r_state <= EMIT_I;
            end else begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_li_encoder.sv
// Directed bench for li_encoder: encodings, stalls, rd==0 and asynchronous reset.
module tb_li_encoder;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_value;
  logic [4:0]  req_rd;
  logic        req_pcrel;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        instr_last;

  int n_checks;
  int n_fail;

  li_encoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_value   (req_value),
    .req_rd      (req_rd),
    .req_pcrel   (req_pcrel),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_last  (instr_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one request for one cycle, then scrambles the request fields.
  task automatic issue(input logic [31:0] v, input logic [4:0] rd, input logic p);
    req_valid = 1'b1;
    req_value = v;
    req_rd    = rd;
    req_pcrel = p;
    @(negedge clk);
    req_valid = 1'b0;
    req_value = 32'hDEAD_BEEF;
    req_rd    = 5'd31;
    req_pcrel = ~p;
  endtask

  task automatic test_reset();
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset req_ready: got %b want 1", req_ready); end
    n_checks++;
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset instr_valid: got %b want 0", instr_valid); end
    n_checks++;
    if (instr !== 32'h0) begin n_fail++; $display("FAIL reset instr: got %h want 00000000", instr); end
    n_checks++;
    if (instr_last !== 1'b0) begin n_fail++; $display("FAIL reset instr_last: got %b want 0", instr_last); end
  endtask

  task automatic test_sequences();
    logic [31:0] t_val [10];
    logic [4:0]  t_rd  [10];
    logic        t_pc  [10];
    int          t_n   [10];
    logic [31:0] t_w0  [10];
    logic [31:0] t_w1  [10];
    logic [31:0] exp_w;
    t_val[0]=32'h12345678; t_rd[0]=5'd5;  t_pc[0]=0; t_n[0]=2; t_w0[0]=32'h123452B7; t_w1[0]=32'h67828293;
    t_val[1]=32'h00000FFF; t_rd[1]=5'd1;  t_pc[1]=0; t_n[1]=2; t_w0[1]=32'h000010B7; t_w1[1]=32'hFFF08093;
    t_val[2]=32'hFFFFF800; t_rd[2]=5'd10; t_pc[2]=0; t_n[2]=1; t_w0[2]=32'h80000513; t_w1[2]=32'h0;
    t_val[3]=32'hABCDE000; t_rd[3]=5'd3;  t_pc[3]=0; t_n[3]=1; t_w0[3]=32'hABCDE1B7; t_w1[3]=32'h0;
    t_val[4]=32'h00000010; t_rd[4]=5'd2;  t_pc[4]=1; t_n[4]=2; t_w0[4]=32'h00000117; t_w1[4]=32'h01010113;
    t_val[5]=32'h7FFFF800; t_rd[5]=5'd1;  t_pc[5]=0; t_n[5]=2; t_w0[5]=32'h800000B7; t_w1[5]=32'h80008093;
    t_val[6]=32'h000007FF; t_rd[6]=5'd4;  t_pc[6]=0; t_n[6]=1; t_w0[6]=32'h7FF00213; t_w1[6]=32'h0;
    t_val[7]=32'hFFFFF800; t_rd[7]=5'd10; t_pc[7]=1; t_n[7]=2; t_w0[7]=32'h00000517; t_w1[7]=32'h80050513;
    t_val[8]=32'h12345678; t_rd[8]=5'd0;  t_pc[8]=0; t_n[8]=1; t_w0[8]=32'h00000013; t_w1[8]=32'h0;
    t_val[9]=32'hABCDE000; t_rd[9]=5'd0;  t_pc[9]=1; t_n[9]=1; t_w0[9]=32'h00000013; t_w1[9]=32'h0;
    instr_ready = 1'b1;
    for (int s = 0; s < 10; s++) begin
      n_checks++;
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL seq%0d req_ready idle: got %b want 1", s, req_ready); end
      issue(t_val[s], t_rd[s], t_pc[s]);
      for (int w = 0; w < t_n[s]; w++) begin
        exp_w = (w == 0) ? t_w0[s] : t_w1[s];
        n_checks++;
        if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL seq%0d w%0d instr_valid: got %b want 1", s, w, instr_valid); end
        n_checks++;
        if (instr !== exp_w) begin n_fail++; $display("FAIL seq%0d w%0d instr: got %h want %h", s, w, instr, exp_w); end
        n_checks++;
        if (instr_last !== (w == t_n[s] - 1)) begin n_fail++; $display("FAIL seq%0d w%0d instr_last: got %b want %b", s, w, instr_last, (w == t_n[s] - 1)); end
        n_checks++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL seq%0d w%0d req_ready busy: got %b want 0", s, w, req_ready); end
        @(negedge clk);
      end
      n_checks++;
      if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL seq%0d done instr_valid: got %b want 0", s, instr_valid); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_w;
    instr_ready = 1'b0;
    issue(32'h12345678, 5'd5, 1'b0);
    for (int w = 0; w < 2; w++) begin
      exp_w = (w == 0) ? 32'h123452B7 : 32'h67828293;
      for (int c = 0; c < 4; c++) begin
        n_checks++;
        if (instr_valid !== 1'b1 || instr !== exp_w || instr_last !== (w == 1)) begin
          n_fail++;
          $display("FAIL stall w%0d c%0d: got v=%b %h last=%b want v=1 %h last=%b", w, c, instr_valid, instr, instr_last, exp_w, (w == 1));
        end
        n_checks++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL stall w%0d c%0d req_ready: got %b want 0", w, c, req_ready); end
        if (c == 3) instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
      end
    end
    n_checks++;
    if (instr_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall done: got v=%b rdy=%b want v=0 rdy=1", instr_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    instr_ready = 1'b0;
    issue(32'h12345678, 5'd5, 1'b0);
    n_checks++;
    if (instr !== 32'h123452B7 || instr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid pre: got v=%b %h want v=1 123452b7", instr_valid, instr);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid instr_valid: got %b want 0", instr_valid); end
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid req_ready: got %b want 1", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    instr_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid stale word: got v=%b %h want v=0", instr_valid, instr); end
    issue(32'h00000FFF, 5'd1, 1'b0);
    n_checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h000010B7 || instr_last !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid w0: got v=%b %h last=%b want v=1 000010b7 last=0", instr_valid, instr, instr_last);
    end
    @(negedge clk);
    n_checks++;
    if (instr_valid !== 1'b1 || instr !== 32'hFFF08093 || instr_last !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid w1: got v=%b %h last=%b want v=1 fff08093 last=1", instr_valid, instr, instr_last);
    end
    @(negedge clk);
    n_checks++;
    if (instr_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid done: got v=%b rdy=%b want v=0 rdy=1", instr_valid, req_ready);
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_value   = 32'h0;
    req_rd      = 5'd0;
    req_pcrel   = 1'b0;
    instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_sequences();
    test_stall();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/li_encoder.md
Name: li_encoder

Overview:
- Immediate encoder: turns a 32-bit constant or PC-relative offset plus a destination register into one or two RV32I instruction words.
- The words are LUI/AUIPC followed by ADDI. This is the inverse of the decode-side U/I-immediate extraction.
- Used by the debug/boot instruction-injection path to feed the fetch queue.
- Stream in via a valid/ready request; stream out via a valid/ready instruction port with a last flag.

Parameters:
- none (RV32I fixed; XLEN 32)

Ports:
- clk          input   1   system clock, rising edge
- rst_n        input   1   asynchronous active-low reset
- req_valid    input   1   request present
- req_ready    output  1   block can accept request
- req_value    input   32  constant (pcrel=0) or PC-relative offset (pcrel=1)
- req_rd       input   5   destination register
- req_pcrel    input   1   0: LUI-based sequence; 1: AUIPC-based sequence
- instr_valid  output  1   instr holds a valid word
- instr_ready  input   1   consumer accepts word
- instr        output  32  encoded instruction
- instr_last   output  1   final word of current sequence

Behaviour:
- Reset values: req_ready=1, instr_valid=0, instr=32'h0, instr_last=0, state=IDLE, all internal registers 0.
- Reset is asynchronous. Asserting rst_n low mid-sequence drops instr_valid immediately. Any remaining word is discarded, with no partial resume.
- States: IDLE, EMIT_U, EMIT_I.
- req_ready=1 only in IDLE. A request is accepted on a cycle with req_valid & req_ready.
- Split on acceptance:
  - lo = value[11:0]
  - hi = (value + 32'h800)[31:12], modulo 2^32; wrap is allowed, e.g. 0x7FFFF800 gives hi=0x80000, lo=0x800.
  - small = pcrel==0 and value in [-2048, 2047], i.e. value[31:11] all-equal.
  - lozero = (lo == 0).
- Sequence selection on acceptance:
  - small: single word ADDI rd,x0,lo; go to EMIT_I with last=1.
  - lozero and not small: single word LUI/AUIPC rd,hi; go to EMIT_U with last=1.
  - otherwise: LUI/AUIPC rd,hi (go to EMIT_U, last=0), then ADDI rd,rd,lo (last=1).
  - rd==0: still emit a single ADDI x0,x0,0 (0x00000013) with last=1. This keeps the handshake count deterministic.
- Encodings:
  - LUI = {hi, rd, 7'b0110111}
  - AUIPC = {hi, rd, 7'b0010111}
  - ADDI = {lo, rs1, 3'b000, rd, 7'b0010011}
- Latency: request accepted at cycle N gives the first word with instr_valid=1 at cycle N+1. All outputs are registered.
- Output hold: while instr_valid & !instr_ready, instr and instr_last are held stable.
- Advance: on instr_valid & instr_ready:
  - last=0: load the ADDI word and go to EMIT_I, valid stays 1, no bubble.
  - last=1: go to IDLE, instr_valid=0, req_ready=1 the next cycle.
- No request overlap. A new request cannot be accepted in the same cycle the last word is consumed, so throughput is at most one request per (words+1) cycles.
- req_value, req_rd and req_pcrel are sampled only at acceptance. Later changes have no effect.

Decomposition:
- Shared package li_pkg holds:
  - opcode constants OPC_LUI, OPC_AUIPC, OPC_OPIMM
  - FUNCT3_ADDI
  - state enum li_state_t {IDLE, EMIT_U, EMIT_I}
- One natural sub-module: li_split, purely combinational. It takes value and pcrel and produces hi, lo, small and lozero. It is reused by the assembler-side tooling model.

Test Plan:
- value=0x12345678, rd=5, pcrel=0, instr_ready=1 -> 0x123452B7 (last=0), then 0x67828293 (last=1) on consecutive cycles; req_ready returns the next cycle.
- value=0x00000FFF, rd=1, pcrel=0 -> LUI 0x000010B7, then ADDI 0xFFF08093 (checks rounding carry into hi).
- value=0xFFFFF800, rd=10, pcrel=0 -> single 0x80000513 with last=1. Then value=0xABCDE000, rd=3 -> single 0xABCDE1B7 with last=1.
- value=0x00000010, rd=2, pcrel=1 -> AUIPC 0x00000117, then ADDI 0x01010113 (no small optimization in pcrel mode).
- 0x12345678/rd=5 with instr_ready low for 3 cycles on each word -> instr and last stable throughout, req_ready=0 until the final accept, no words lost or duplicated. Also rd=0 with any value -> single 0x00000013.
- Assert rst_n low while EMIT_U is stalled -> instr_valid=0 and req_ready=1 immediately. After release the next request encodes correctly, with no stale ADDI emitted.
